// File: rtl/find_extreme_pkg.sv
// find_extreme_pkg: shared types and default widths for the extreme finder.
//   state_t : FSM states IDLE, ACTIVE, DONE
//   mode_t  : MODE_MAX (0) / MODE_MIN (1)
//   DEF_WIDTH, DEF_IDX_W : default sample and index widths
package find_extreme_pkg;
    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
    typedef enum logic {MODE_MAX = 1'b0, MODE_MIN = 1'b1} mode_t;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_IDX_W = 8;
endpackage

// File: rtl/find_extreme_if.sv
// find_extreme_if: sample stream in, running extreme result out.
//   master : start, mode, in_valid, in_data driven; result signals observed
//   slave  : the finder itself
interface find_extreme_if
    import find_extreme_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDX_W = DEF_IDX_W
);
    logic             start;
    logic             mode;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] ext_value;
    logic [IDX_W-1:0] ext_idx;
    logic [IDX_W-1:0] sample_cnt;
    logic             result_valid;
    logic             busy;
    logic             done;
    modport master (
        output start, mode, in_valid, in_data,
        input  ext_value, ext_idx, sample_cnt, result_valid, busy, done
    );
    modport slave (
        input  start, mode, in_valid, in_data,
        output ext_value, ext_idx, sample_cnt, result_valid, busy, done
    );
endinterface

// File: rtl/find_extreme_cmp.sv
// extreme_cmp: combinational "a strictly beats b" test for max or min mode.
//   a, b   : candidate sample and current extreme
//   mode   : MODE_MAX / MODE_MIN
//   better : a is strictly greater (max) or strictly smaller (min) than b
// Signed two's-complement compare when FIND_EXTREME_SIGNED_EN is defined,
// unsigned otherwise.
module extreme_cmp
    import find_extreme_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  mode_t            mode,
    output logic             better
);
`ifdef FIND_EXTREME_SIGNED_EN
    assign better = (mode == MODE_MIN) ? ($signed(a) < $signed(b)) : ($signed(a) > $signed(b));
`else
    assign better = (mode == MODE_MIN) ? (a < b) : (a > b);
`endif
endmodule

// File: rtl/find_extreme.sv
// find_extreme: tracks the running max/min of a start-framed sample stream,
// with the index of the winning sample and a saturating sample count.
//   clk, rst : clock, synchronous active-low reset
//   bus      : find_extreme_if.slave (start/mode/in_valid/in_data in;
//              ext_value/ext_idx/sample_cnt/result_valid/busy/done out)
// FIND_EXTREME_SIGNED_EN selects signed comparison (see extreme_cmp).
module find_extreme
    import find_extreme_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDX_W = DEF_IDX_W
) (
    input  logic          clk,
    input  logic          rst,
    find_extreme_if.slave bus
);
    localparam logic [IDX_W-1:0] CNT_MAX = '1;
    localparam logic [IDX_W-1:0] CNT_ONE = IDX_W'(1);

    state_t           state, state_nx;
    mode_t            mode_q;
    logic [WIDTH-1:0] val_q;
    logic [IDX_W-1:0] idx_q, cnt_q;
    logic             rv_q;
    logic             entry, accept, first, better;

    assign entry  = (state == IDLE) && bus.start;
    assign accept = bus.start && bus.in_valid && (state != DONE);
    // The first accepted sample loads unconditionally; registers cleared on
    // entry may still hold the previous sequence in the entry cycle.
    assign first  = entry || !rv_q;

    extreme_cmp #(.WIDTH(WIDTH)) u_cmp (
        .a      (bus.in_data),
        .b      (val_q),
        .mode   (mode_q),
        .better (better)
    );

    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE && bus.start)    ? ACTIVE :
                   (state == ACTIVE && !bus.start) ? DONE   :
                   (state == DONE)                 ? IDLE   : state;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            mode_q <= MODE_MAX;
            val_q  <= '0;
            idx_q  <= '0;
            cnt_q  <= '0;
            rv_q   <= 1'b0;
        end else begin
            state <= state_nx;
            if (entry) begin
                mode_q <= mode_t'(bus.mode);
                val_q  <= '0;
                idx_q  <= '0;
                cnt_q  <= '0;
                rv_q   <= 1'b0;
            end
            if (accept && first) begin
                val_q <= bus.in_data;
                idx_q <= '0;
                cnt_q <= CNT_ONE;
                rv_q  <= 1'b1;
            end else if (accept) begin
                // cnt_q is this sample's index; once saturated it pins at max.
                if (better) begin
                    val_q <= bus.in_data;
                    idx_q <= cnt_q;
                end
                cnt_q <= (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            end
        end
    end

    assign bus.ext_value    = val_q;
    assign bus.ext_idx      = idx_q;
    assign bus.sample_cnt   = cnt_q;
    assign bus.result_valid = rv_q;
    assign bus.busy         = (state == ACTIVE);
    assign bus.done         = (state == DONE);
endmodule

// File: tb/tb_find_extreme.sv
// tb_find_extreme: scoreboard bench for find_extreme (IDX_W=8 and IDX_W=2 instances).
module tb_find_extreme;
    import find_extreme_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0, mode = 1'b0, in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;

    always #5 clk = ~clk;

    find_extreme_if #(.WIDTH(8), .IDX_W(8)) a_if ();
    find_extreme_if #(.WIDTH(8), .IDX_W(2)) b_if ();

    assign a_if.start = start;
    assign a_if.mode = mode;
    assign a_if.in_valid = in_valid;
    assign a_if.in_data = in_data;
    assign b_if.start = start;
    assign b_if.mode = mode;
    assign b_if.in_valid = in_valid;
    assign b_if.in_data = in_data;

    find_extreme #(.WIDTH(8), .IDX_W(8)) u_a (.clk(clk), .rst(rst), .bus(a_if.slave));
    find_extreme #(.WIDTH(8), .IDX_W(2)) u_b (.clk(clk), .rst(rst), .bus(b_if.slave));

    typedef struct packed {
        logic [7:0] val;
        logic [7:0] idx;
        logic [7:0] cnt;
        logic       rv;
    } exp_t;

    exp_t       qa[$], qb[$];
    logic [7:0] cur[$];
    int         checks = 0;
    int         failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic bit beats(input logic [7:0] x, input logic [7:0] y, input logic m);
`ifdef FIND_EXTREME_SIGNED_EN
        return m ? ($signed(x) < $signed(y)) : ($signed(x) > $signed(y));
`else
        return m ? (x < y) : (x > y);
`endif
    endfunction

    // Earliest strict extreme of the accepted samples; index and count clip at maxv.
    function automatic exp_t model(input logic m, input int maxv);
        exp_t e;
        int   best = 0;
        for (int i = 1; i < cur.size(); i++)
            if (beats(cur[i], cur[best], m)) best = i;
        e.rv  = cur.size() > 0;
        e.val = (cur.size() > 0) ? cur[best] : 8'h00;
        e.idx = 8'((best < maxv) ? best : maxv);
        e.cnt = 8'((cur.size() < maxv) ? cur.size() : maxv);
        return e;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drives one sequence; returns in the DONE cycle. With junk, first spends
    // the current (DONE) cycle with start high and a sample that must be ignored.
    task automatic run_seq(input logic m, input bit junk, input int empty_len);
        int g;
        if (junk) begin
            start = 1'b1; in_valid = 1'b1; in_data = 8'($urandom); mode = ~m;
            cyc();
        end
        start = 1'b1;
        mode = m;
        if (cur.size() == 0)
            for (int i = 0; i < empty_len; i++) begin
                in_valid = 1'b0; in_data = 8'($urandom);
                cyc();
                mode = 1'($urandom);
            end
        for (int i = 0; i < cur.size(); i++) begin
            g = $urandom_range(0, 2);
            for (int j = 0; j < g; j++) begin
                in_valid = 1'b0; in_data = 8'($urandom);
                cyc();
                mode = 1'($urandom);
            end
            in_valid = 1'b1; in_data = cur[i];
            cyc();
            mode = 1'($urandom);
        end
        start = 1'b0; in_valid = 1'($urandom); in_data = 8'($urandom);
        qa.push_back(model(m, 255));
        qb.push_back(model(m, 3));
        cyc();
        chk("done_pulse", int'(a_if.done), 1);
        chk("busy_in_done", int'(a_if.busy), 0);
    endtask

    task automatic idle();
        start = 1'b0; in_valid = 1'($urandom); in_data = 8'($urandom);
        cyc();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst && a_if.done) begin
            if (qa.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_done_a actual=1 expected=0");
            end else begin
                e = qa.pop_front();
                chk("a_value", int'(a_if.ext_value), int'(e.val));
                chk("a_idx", int'(a_if.ext_idx), int'(e.idx));
                chk("a_cnt", int'(a_if.sample_cnt), int'(e.cnt));
                chk("a_rv", int'(a_if.result_valid), int'(e.rv));
            end
        end
        if (rst && b_if.done) begin
            if (qb.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_done_b actual=1 expected=0");
            end else begin
                e = qb.pop_front();
                chk("b_value", int'(b_if.ext_value), int'(e.val));
                chk("b_idx", int'(b_if.ext_idx), int'(e.idx));
                chk("b_cnt", int'(b_if.sample_cnt), int'(e.cnt));
                chk("b_rv", int'(b_if.result_valid), int'(e.rv));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit junk;
        int n;
        bit narrow;
        repeat (3) cyc();
        chk("rst_value", int'(a_if.ext_value), 0);
        chk("rst_idx", int'(a_if.ext_idx), 0);
        chk("rst_cnt", int'(a_if.sample_cnt), 0);
        chk("rst_rv", int'(a_if.result_valid), 0);
        chk("rst_busy", int'(a_if.busy), 0);
        chk("rst_done", int'(a_if.done), 0);
        rst = 1'b1;
        cyc();
        cur = '{8'd3, 8'd9, 8'd4, 8'd9, 8'd1};
        run_seq(1'b0, 1'b0, 0); idle();
        cur = '{8'd7, 8'd2, 8'd2, 8'd5};
        run_seq(1'b1, 1'b0, 0); idle();
        cur.delete();
        run_seq(1'b0, 1'b0, 3); idle();
        cur = '{8'h80, 8'hF0, 8'h05};
        run_seq(1'b0, 1'b0, 0); idle();
        cur = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'hFF};
        run_seq(1'b0, 1'b0, 0); idle();
        cur.delete();
        run_seq(1'b1, 1'b0, 1); idle();
        // Reset lands in the third cycle of a sequence.
        start = 1'b1; mode = 1'b0; in_valid = 1'b1; in_data = 8'd50;
        cyc();
        in_data = 8'd60;
        cyc();
        rst = 1'b0; in_data = 8'd70;
        cyc();
        chk("abort_value", int'(a_if.ext_value), 0);
        chk("abort_cnt", int'(a_if.sample_cnt), 0);
        chk("abort_rv", int'(a_if.result_valid), 0);
        chk("abort_busy", int'(a_if.busy), 0);
        chk("abort_done", int'(a_if.done), 0);
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        cyc();
        cur = '{8'd10, 8'd20, 8'd5};
        run_seq(1'b0, 1'b0, 0);
        repeat (40) begin
            junk = 1'($urandom);
            n = $urandom_range(0, 12);
            narrow = 1'($urandom);
            cur.delete();
            for (int i = 0; i < n; i++)
                cur.push_back(narrow ? 8'($urandom_range(0, 3)) : 8'($urandom));
            if (!junk) idle();
            run_seq(1'($urandom), junk, $urandom_range(1, 3));
        end
        idle();
        repeat (3) cyc();
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
